// File: rtl/non_restoring_div_32_bit.sv
// Sequential 32-bit signed non-restoring divider, one quotient bit per clock.
// Ports:
//   clock, clear (async active-low reset)
//   start        one-cycle request, accepted only in IDLE
//   a, b         signed dividend / divisor, sampled at the accepting edge
//   busy, done   handshake; done is a one-cycle pulse
//   quotient, remainder, z = {remainder, quotient} for HI:LO
//   div_by_zero  divide-by-zero flag (live only with DIV0_CHECK_EN)
// Optional feature macro: DIV0_CHECK_EN (b==0 short-circuits to FIX).
module non_restoring_div_32_bit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [63:0] z,
  output logic        div_by_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [W:0]    r_a,     w_a_nxt;
  logic [W-1:0]  r_q,     w_q_nxt;
  logic [W-1:0]  r_m,     w_m_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_neg_rem, w_neg_rem_nxt;
  logic          r_neg_quo, w_neg_quo_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic [W-1:0]  r_quo,   w_quo_nxt;
  logic [W-1:0]  r_rem,   w_rem_nxt;

  // Shifted partial remainder and the add/subtract step that follows it
  logic [W:0]    w_a_sh;
  logic [W:0]    w_a_step;
  logic [W:0]    w_a_fix;

  // |A| stays below M <= 2^31, so A[31:0] keeps the sign across the shift
  assign w_a_sh   = {r_a[W-1:0], r_q[W-1]};
  assign w_a_step = r_a[W] ? (w_a_sh + {1'b0, r_m}) : (w_a_sh - {1'b0, r_m});
  assign w_a_fix  = r_a[W] ? (r_a + {1'b0, r_m}) : r_a;

`ifdef DIV0_CHECK_EN
  logic r_b_zero, w_b_zero_nxt;
  logic r_div0,   w_div0_nxt;
`endif

  // Next-state and datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_q_nxt       = r_q;
    w_m_nxt       = r_m;
    w_cnt_nxt     = r_cnt;
    w_neg_rem_nxt = r_neg_rem;
    w_neg_quo_nxt = r_neg_quo;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_quo_nxt     = r_quo;
    w_rem_nxt     = r_rem;
`ifdef DIV0_CHECK_EN
    w_b_zero_nxt  = r_b_zero;
    w_div0_nxt    = r_div0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_q_nxt       = a[W-1] ? (~a + W'(1)) : a;
          w_m_nxt       = b[W-1] ? (~b + W'(1)) : b;
          w_neg_rem_nxt = a[W-1];
          w_neg_quo_nxt = a[W-1] ^ b[W-1];
          w_a_nxt       = '0;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_ITER;
`ifdef DIV0_CHECK_EN
          w_div0_nxt    = 1'b0;
          w_b_zero_nxt  = (b == '0);
          if (b == '0) w_state_nxt = S_FIX;
`endif
        end
      end
      S_ITER: begin
        w_a_nxt   = w_a_step;
        w_q_nxt   = {r_q[W-2:0], ~w_a_step[W]};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(31)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_a_nxt     = w_a_fix;
        w_quo_nxt   = r_neg_quo ? (~r_q + W'(1)) : r_q;
        w_rem_nxt   = r_neg_rem ? (~w_a_fix[W-1:0] + W'(1)) : w_a_fix[W-1:0];
`ifdef DIV0_CHECK_EN
        // Q still holds |a|; restoring its sign gives back a
        if (r_b_zero) begin
          w_quo_nxt  = '1;
          w_rem_nxt  = r_neg_rem ? (~r_q + W'(1)) : r_q;
          w_div0_nxt = 1'b1;
        end
`endif
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_neg_rem <= 1'b0;
      r_neg_quo <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
`ifdef DIV0_CHECK_EN
      r_b_zero  <= 1'b0;
      r_div0    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_q       <= w_q_nxt;
      r_m       <= w_m_nxt;
      r_cnt     <= w_cnt_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_neg_quo <= w_neg_quo_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_quo     <= w_quo_nxt;
      r_rem     <= w_rem_nxt;
`ifdef DIV0_CHECK_EN
      r_b_zero  <= w_b_zero_nxt;
      r_div0    <= w_div0_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign z         = {r_rem, r_quo};
`ifdef DIV0_CHECK_EN
  assign div_by_zero = r_div0;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: doc/non_restoring_div_32_bit.md
# non_restoring_div_32_bit

Sequential 32-bit signed divider, the inverse of the bit-pair Booth multiplier in the ALU datapath. It retires one quotient bit per clock with non-restoring division and produces quotient and remainder packed as a 64-bit result. The result maps onto the same HI/LO register pair that the multiplier writes: remainder goes to HI and quotient goes to LO. The ALU control FSM starts it with a single-cycle `start` pulse and waits for `done`.

## Interface
- Parameters: none; width fixed at 32.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `clear`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `a`  in  32  signed dividend; sampled at the accepting edge only.
- `b`  in  32  signed divisor; sampled at the accepting edge only.
- `busy`  out  1  high from the accepting edge until `done` is issued.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `quotient`  out  32  signed quotient.
- `remainder`  out  32  signed remainder.
- `z`  out  64  `{remainder, quotient}`, for HI:LO.
- `div_by_zero`  out  1  registered flag; meaningful only with `DIV0_CHECK_EN`.

## Operation
- States: IDLE, ITER, FIX, DONE.
- **IDLE, `start`=1:**
  - Latch |a| into Q and |b| into M.
  - Latch sign(a) and sign(a)^sign(b).
  - Clear the 33-bit accumulator A and the 5-bit counter.
  - Go to ITER.
- **ITER (32 cycles):** each cycle:
  - Shift {A,Q} left by 1.
  - If A was ≥0 before the shift, A = A − M; otherwise A = A + M.
  - Q[0] = ~A[32] (the new sign).
  - The counter increments; leave ITER when the counter wraps from 31.
- **FIX:**
  - If A<0, A = A + M (restore the remainder).
  - Negate Q if the signs differed; negate A[31:0] if the dividend was negative.
  - Register `quotient`, `remainder` and `div_by_zero`.
- **DONE:** `done`=1 for exactly this cycle, `busy`=0; then return to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend, with |remainder| < |b|.
  - |a| uses 32-bit two's-complement wrap, so |0x80000000| = 0x80000000 (treated as unsigned magnitude).
  - 0x80000000 / −1 gives quotient 0x80000000, remainder 0 (wrap, no flag).
- Outputs hold their last results until the next FIX or reset.
- A `start` pulse while `busy` is ignored; it is neither queued nor allowed to corrupt the operation.
- Reset: every output goes to 0 (`busy`, `done`, `quotient`, `remainder`, `z`, `div_by_zero`) and the state goes to IDLE.
- Reset mid-operation: the operation is aborted, no `done` is issued, and the block accepts `start` normally after `clear` deasserts.

## Timing
- Accepting edge E: `busy` is high after E.
- ITER occupies edges E+1 to E+32 and FIX occurs at edge E+33.
- `done` is high in the cycle after edge E+33; `busy` falls at that same edge.
- IDLE is reached at E+34.
- Back-to-back operation: a `start` sampled in the cycle after `done` (the IDLE cycle) is accepted.
- Throughput: one division per 35 cycles.
- `start` seen during the DONE cycle is ignored.
- No combinational path from inputs to outputs.

## Configuration
- `DIV0_CHECK_EN` defined:
  - If b==0 at the accepting edge, go straight to FIX (skip ITER).
  - FIX forces `quotient`=0xFFFFFFFF, `remainder`=a and `div_by_zero`=1.
  - `done` appears in the cycle after E+1.
  - `div_by_zero` clears on the next accepted `start`.
- Undefined:
  - `div_by_zero` is tied to 0 and b==0 runs the full 34-cycle sequence.
  - For a≥0 the result is quotient 0xFFFFFFFF, remainder a.
  - For a<0 the result is whatever the algorithm yields; the bench does not check it.

## Test plan
- a=100, b=7 -> after 34 cycles `done`=1, quotient=14, remainder=2, z=0x00000002_0000000E.
- a=−100, b=7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
- a=100, b=−7 -> quotient=0xFFFFFFF2, remainder=2.
- a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- a=0x80000000, b=1 -> quotient=0x80000000, remainder=0.
- Divide by zero, a=5, b=0, with `DIV0_CHECK_EN` -> `done` after 2 cycles, quotient=0xFFFFFFFF, remainder=5, `div_by_zero`=1.
- Divide by zero, a=5, b=0, without the macro -> `done` after 34 cycles, same values, `div_by_zero`=0.
- Start a=100, b=7, then pulse `start` with a=9, b=3 at cycle 10 -> the pulse is ignored and the result is 14 r 2.
- Separately, assert `clear` at cycle 15 -> all outputs 0 with no `done`; then 9/3 -> quotient 3, remainder 0.
